// File: rtl/decryptor.sv
// ---------------------------------------------------------------------------
// decryptor
//   RSA decryption engine. Computes m = c^D mod N for one 16-bit ciphertext
//   word with right-to-left square-and-multiply, one exponent bit per clock,
//   and presents m[7:0] as the decrypted character.
//
//   There is no handshake. Any change on encrypted_char starts a new
//   decryption, and a change arriving mid-computation aborts the current one.
//   After reset, the first word is decrypted even when it equals the reset
//   value of the last-seen register.
//
// Ports
//   clk             in   1   rising-edge clock
//   reset           in   1   asynchronous, active-high reset
//   encrypted_char  in  16   ciphertext word c
//   decrypted_char  out  8   registered plaintext byte m[7:0]
//
// Timing: the word is captured at edge 1, exponent bits are consumed at
// edges 2..DBITS+1, and decrypted_char updates at edge DBITS+2.
// N must be at least 256 so that result[7:0] exists.
// ---------------------------------------------------------------------------
module decryptor #(
  parameter int N     = 3233,
  parameter int D     = 2753,
  parameter int DBITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] encrypted_char,
  output logic [7:0]  decrypted_char
);

  // Operands are kept reduced below N, so NW bits hold them and 2*NW bits
  // hold any product of two of them.
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [15:0]       N_IN   = 16'(N);
  localparam logic [2*NW-1:0]   N_PROD = (2*NW)'(N);
  localparam logic [DBITS-1:0]  D_VEC  = DBITS'(D);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [NW-1:0]    r_result;
  logic [NW-1:0]    r_base;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_last_c;
  logic             r_have_input;

  logic             w_start;
  logic             w_dbit;
  logic             w_last_bit;
  logic [2*NW-1:0]  w_prod_rb;
  logic [2*NW-1:0]  w_prod_bb;
  logic [NW-1:0]    w_mul_rb;
  logic [NW-1:0]    w_sqr_bb;
  logic [NW-1:0]    w_base_init;

  // Start detection and the two single-cycle modular products.
  always_comb begin
    w_start     = (encrypted_char != r_last_c) || !r_have_input;
    w_dbit      = D_VEC[r_cnt];
    w_last_bit  = (r_cnt == CNT_LAST);
    w_prod_rb   = (2*NW)'(r_result) * (2*NW)'(r_base);
    w_prod_bb   = (2*NW)'(r_base) * (2*NW)'(r_base);
    w_mul_rb    = NW'(w_prod_rb % N_PROD);
    w_sqr_bb    = NW'(w_prod_bb % N_PROD);
    // Inputs >= N are reduced before the first squaring.
    w_base_init = NW'(encrypted_char % N_IN);
  end

  // Control FSM and datapath registers; a start condition takes priority in
  // every state, so an input change aborts RUN/DONE without writing out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_result       <= NW'(1);
      r_base         <= '0;
      r_cnt          <= '0;
      r_last_c       <= 16'h0000;
      r_have_input   <= 1'b0;
      decrypted_char <= 8'h00;
    end else if (w_start) begin
      r_last_c     <= encrypted_char;
      r_have_input <= 1'b1;
      r_base       <= w_base_init;
      r_result     <= NW'(1);
      r_cnt        <= '0;
      r_state      <= S_RUN;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_RUN: begin
          if (w_dbit) begin
            r_result <= w_mul_rb;
          end else begin
            r_result <= r_result;
          end
          r_base <= w_sqr_bb;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last_bit) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          decrypted_char <= r_result[7:0];
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decryptor.sv
// ---------------------------------------------------------------------------
// tb_decryptor
//   Directed bench for decryptor with a scoreboard queue: the expected
//   plaintext is pushed when a ciphertext word is driven and popped when the
//   output is due (14 edges later). Outputs are sampled 1 time unit after
//   the rising edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_decryptor;

  logic        clk;
  logic        reset;
  logic [15:0] encrypted_char;
  logic [7:0]  decrypted_char;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] sb_q[$];

  decryptor dut (
    .clk            (clk),
    .reset          (reset),
    .encrypted_char (encrypted_char),
    .decrypted_char (decrypted_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain modular exponentiation used only to build encryption test vectors.
  function automatic int unsigned modexp(input int unsigned b, input int unsigned e,
                                         input int unsigned m);
    int unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  // Pop the expected value after the output edge (edge 14) and re-check it
  // one edge later to confirm it stays put within the hold window.
  task automatic await_result(input string tag);
    logic [7:0] e;
    repeat (14) @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(tag, decrypted_char, e);
    @(posedge clk);
    #1;
    check({tag, "_stable"}, decrypted_char, e);
  endtask

  task automatic word(input logic [15:0] c, input logic [7:0] m, input string tag);
    @(negedge clk);
    encrypted_char = c;
    sb_q.push_back(m);
    await_result(tag);
  endtask

  initial begin
    reset          = 1'b1;
    encrypted_char = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", decrypted_char, 8'h00);

    // First word after reset is 0: decrypted via have_input.
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(8'h00);
    await_result("first_zero");

    word(16'h0AE6, 8'h41, "c_2790");
    word(16'h0001, 8'h01, "c_one");
    word(16'h1787, 8'h41, "c_6023_prereduce");
    word(16'd3233, 8'h00, "c_eq_N");

    // Abort: 0x0AE6 held 5 clocks, then 1. 'A' must never appear; output
    // keeps the old 0x00 until 14 edges after the change.
    @(negedge clk);
    encrypted_char = 16'h0AE6;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("abort_pre", decrypted_char, 8'h00);
    end
    @(negedge clk);
    encrypted_char = 16'h0001;
    sb_q.push_back(8'h01);
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk);
      #1;
      check("abort_hold_old", decrypted_char, 8'h00);
    end
    @(posedge clk);
    #1;
    check("abort_edge14", decrypted_char, sb_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_after", decrypted_char, 8'h01);
    end

    // Reset during RUN: output clears at once, held input recomputed after.
    @(negedge clk);
    encrypted_char = 16'h0AE6;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_run", decrypted_char, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(8'h41);
    await_result("after_reset_recompute");

    // Printable ASCII sweep using the public exponent 17.
    for (int m = 32; m <= 126; m++) begin
      word(16'(modexp(32'(m), 32'd17, 32'd3233)), 8'(m), "sweep");
    end

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
